stage_f_pq: RTL
===============

// Module: stage_f_pq
// PURPOSE
// Parametrised Polaris instruction fetch stage with a prefetch queue.
// - Drives the F-Bus (32-bit instruction Wishbone master, asynchronous-memory friendly).
// - Buffers fetched words with their PCs in a DEPTH-entry FIFO.
// - Presents the FIFO head to decode through a valid/ready handshake.
// - Supports PC redirect (branch/trap) with queue flush, and flags bus errors per entry.
// PARAMETERS
// AW        64                   address width in bits; f_adr_o/PCs are [AW-1:2]
// DEPTH     4                    prefetch queue entries; power of two, >= 2
// RESET_PC  {AW{1'b1}} << 8      byte-address reset vector (0xFFFF_FFFF_FFFF_FF00 at AW=64); bits [1:0] ignored
// PORTS
// clk_i          in   1         clock; all state changes on posedge
// reset_i        in   1         asynchronous, active-high reset
// f_cyc_o        out  1         bus cycle request; implies f_stb_o and f_sel=4'hF
// f_ack_i        in   1         fetch complete, f_dat_i valid; may arrive the same cycle as the request
// f_err_i        in   1         fetch terminated with error; has priority over f_ack_i
// f_adr_o        out  AW-2      word address of the current fetch (the fetch PC)
// f_dat_i        in   32        instruction word
// d_valid_o      out  1         queue head valid
// d_ready_i      in   1         decode accepts the head this cycle
// d_inst_o       out  32        head instruction; 32'h0000_0013 (NOP) when the entry has error
// d_pc_o         out  AW-2      head word PC
// d_err_o        out  1         head entry was fetched with f_err_i
// redirect_i     in   1         load new fetch PC and flush the queue
// redirect_pc_i  in   AW-2      new word PC
// BEHAVIOUR
// - Reset (async assert, sync release): fpc=RESET_PC>>2, count=0, run_q=0, rd/wr ptr=0.
//   - Outputs during reset: f_cyc_o=0, d_valid_o=0, f_adr_o=RESET_PC>>2.
//   - run_q sets on the first clock edge after release, so f_cyc_o first rises 1 cycle after release.
// - f_cyc_o = run_q & (count != DEPTH) & ~redirect_i.
//   - Depends on registered count only; no combinational path from d_ready_i.
// - f_adr_o = fpc. fpc holds until the fetch terminates. Termination = f_cyc_o & (f_ack_i | f_err_i).
// - On termination, enqueue {fpc, f_dat_i, f_err_i} at wr_ptr, then fpc <= fpc+1.
//   - Latency is 0 wait states when ack is same-cycle.
//   - Entry is visible at d_valid_o the next cycle.
// - fpc increment wraps modulo 2^(AW-2) with no fault.
// - f_ack_i/f_err_i while f_cyc_o=0 are ignored: no enqueue, no PC change.
// - After an f_err_i entry, fetch continues at fpc+1; decode decides whether to trap and redirect.
// - Dequeue when d_valid_o & d_ready_i: rd_ptr++.
// - d_valid_o = (count != 0). d_inst_o/d_pc_o/d_err_o come from rd_ptr and are stable while d_valid_o & ~d_ready_i.
// - Enqueue and dequeue in the same cycle: count unchanged. Both pointers wrap modulo DEPTH.
// - Full (count==DEPTH): no request; a dequeue that cycle frees the slot, so f_cyc_o rises the next cycle.
// - Empty: d_valid_o=0 and d_ready_i is don't-care. There is no bypass from f_dat_i to d_inst_o.
// - Redirect cycle (redirect_i=1), which has priority over everything:
//   - f_cyc_o=0; any ack/err is discarded; any dequeue is ignored.
//   - Next edge: count=0, rd/wr ptr=0, fpc=redirect_pc_i.
//   - Next cycle: d_valid_o=0 and f_cyc_o=1 at the new PC.
//   - Back-to-back redirects: the last one wins.
// - reset_i asserted mid-transaction aborts immediately: f_cyc_o drops asynchronously and queue contents are lost.
// TESTING
// 1 Reset release, memory acks every cycle, d_ready_i=1
//   -> f_adr_o sequence 0x3FFF_FFFF_FFFF_FFC0, ...C1, ...; each d_pc_o appears 1 cycle after its fetch; no gaps.
// 2 d_ready_i=0, DEPTH=4
//   -> exactly 4 enqueues, then f_cyc_o=0 with f_adr_o=RESET+4;
//   -> raise d_ready_i for 1 cycle: one pop, f_cyc_o=1 the next cycle, one further fetch.
// 3 Queue holding 3 entries, redirect_i=1 with redirect_pc_i=0x100 while f_ack_i=1
//   -> ack discarded, next cycle d_valid_o=0, f_adr_o=0x100; first entry later popped has d_pc_o=0x100.
// 4 f_err_i=1 and f_ack_i=1 on the fetch at PC 0x200
//   -> entry shows d_err_o=1, d_inst_o=32'h13; the following entry is PC 0x201 with d_err_o=0.
// 5 Ack withheld 3 cycles (random wait states)
//   -> f_adr_o stable and f_cyc_o high throughout; exactly one enqueue on the ack cycle.
// 6 AW=32, fpc=0x3FFF_FFFF, ack
//   -> next f_adr_o=0 (wrap). Also: reset asserted mid-fetch -> f_cyc_o=0 and d_valid_o=0 asynchronously.

Source files
------------

// File: rtl/stage_f_pq_if.sv
// Fetch-stage bundle: F-Bus instruction master, decode handshake and redirect.
// The fetch stage takes the master modport; memory/decode/branch logic take the slave side.
interface stage_f_pq_if #(
  parameter int unsigned AW = 64
);
  logic          f_cyc_o;
  logic          f_ack_i;
  logic          f_err_i;
  logic [AW-3:0] f_adr_o;
  logic [31:0]   f_dat_i;

  logic          d_valid_o;
  logic          d_ready_i;
  logic [31:0]   d_inst_o;
  logic [AW-3:0] d_pc_o;
  logic          d_err_o;

  logic          redirect_i;
  logic [AW-3:0] redirect_pc_i;

  modport master (
    output f_cyc_o, f_adr_o,
    input  f_ack_i, f_err_i, f_dat_i,
    output d_valid_o, d_inst_o, d_pc_o, d_err_o,
    input  d_ready_i,
    input  redirect_i, redirect_pc_i
  );

  modport slave (
    input  f_cyc_o, f_adr_o,
    output f_ack_i, f_err_i, f_dat_i,
    input  d_valid_o, d_inst_o, d_pc_o, d_err_o,
    output d_ready_i,
    output redirect_i, redirect_pc_i
  );
endinterface

// File: rtl/stage_f_pq.sv
// Polaris instruction fetch stage: F-Bus word fetcher feeding a DEPTH-entry
// prefetch queue that decode drains through a valid/ready handshake.
module stage_f_pq #(
  parameter int unsigned    AW       = 64,
  parameter int unsigned    DEPTH    = 4,
  parameter logic [AW-1:0]  RESET_PC = {AW{1'b1}} << 8
) (
  input  logic           clk_i,
  input  logic           reset_i,
  stage_f_pq_if.master   bus
);

  localparam int unsigned   PW        = AW - 2;
  localparam int unsigned   PTRW      = $clog2(DEPTH);
  localparam int unsigned   CW        = PTRW + 1;
  localparam logic [PW-1:0] RESET_WPC = RESET_PC[AW-1:2];
  localparam logic [CW-1:0] FULL      = CW'(DEPTH);
  localparam logic [31:0]   NOP_INST  = 32'h0000_0013;

  typedef struct packed {
    logic [PW-1:0] pc;
    logic [31:0]   inst;
    logic          err;
  } entry_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t          state_q;
  state_t          state_d;

  logic [PW-1:0]   fpc_q;
  logic [PW-1:0]   fpc_d;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   count_d;
  logic [PTRW-1:0] rd_ptr_q;
  logic [PTRW-1:0] rd_ptr_d;
  logic [PTRW-1:0] wr_ptr_q;
  logic [PTRW-1:0] wr_ptr_d;

  entry_t          mem_q [DEPTH];
  entry_t          head_c;

  logic            f_cyc_c;
  logic            take_c;
  logic            pop_c;
  logic            not_empty_c;

  // State register: fetching starts one edge after reset release.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus request: only from registered occupancy and redirect, never from d_ready_i.
  always_comb begin
    f_cyc_c = 1'b0;
    case (state_q)
      ST_RUN:  f_cyc_c = (count_q != FULL) & ~bus.redirect_i;
      default: f_cyc_c = 1'b0;
    endcase
  end

  assign not_empty_c = (count_q != '0);
  assign take_c      = f_cyc_c & (bus.f_ack_i | bus.f_err_i);
  assign pop_c       = not_empty_c & bus.d_ready_i & ~bus.redirect_i;

  // Queue bookkeeping; a redirect flushes everything and reloads the fetch PC.
  always_comb begin
    fpc_d    = fpc_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (bus.redirect_i) begin
      fpc_d    = bus.redirect_pc_i;
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (take_c) begin
        fpc_d    = fpc_q + PW'(1);
        wr_ptr_d = wr_ptr_q + PTRW'(1);
      end
      if (pop_c) begin
        rd_ptr_d = rd_ptr_q + PTRW'(1);
      end
      count_d = count_q + CW'(take_c) - CW'(pop_c);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      fpc_q    <= RESET_WPC;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      fpc_q    <= fpc_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Entry storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk_i) begin
    if (take_c) begin
      mem_q[wr_ptr_q] <= '{pc: fpc_q, inst: bus.f_dat_i, err: bus.f_err_i};
    end
  end

  assign head_c = mem_q[rd_ptr_q];

  assign bus.f_cyc_o   = f_cyc_c;
  assign bus.f_adr_o   = fpc_q;
  assign bus.d_valid_o = not_empty_c;
  assign bus.d_inst_o  = head_c.err ? NOP_INST : head_c.inst;
  assign bus.d_pc_o    = head_c.pc;
  assign bus.d_err_o   = head_c.err;

endmodule
